// File: rtl/booth_csa_multiplier.sv
// Iterative radix-4 Booth multiplier for RV32M (MUL/MULH/MULHSU/MULHU).
// The full 2N-bit product is formed by retiring one Booth digit per cycle into a
// redundant sum/carry pair through a single 3:2 CSA row. One final
// carry-propagate add then resolves the result.
//
// Ports:
//   CLK          clock, rising edge
//   nRST         asynchronous active-low reset
//   multiplicand operand A, sampled when a start is accepted
//   multiplier   operand B, sampled when a start is accepted
//   is_signed    [1]: A signed, [0]: B signed; sampled with the operands
//   start        level-sensitive request, accepted only in idle
//   flush        synchronous abort, has priority over start
//   busy         a multiply is in flight
//   finished     one-cycle pulse, product valid in this cycle
//   product      registered 2N-bit result, held until the next completion
module booth_csa_multiplier #(
   parameter int unsigned N = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic [N-1:0]     multiplicand,
   input  logic [N-1:0]     multiplier,
   input  logic [1:0]       is_signed,
   input  logic             start,
   input  logic             flush,
   output logic             busy,
   output logic             finished,
   output logic [2*N-1:0]   product
);

   localparam int unsigned P  = 2 * N;
   localparam int unsigned CW = $clog2(N / 2 + 1);
   localparam logic [CW-1:0] LastDigit = CW'(N / 2);

   typedef enum logic [1:0] {StIdle, StBusy, StAdd} state_t;

   state_t          state, state_nxt;
   logic [P-1:0]    mcand, mcand_nxt;
   logic [N+2:0]    mplier, mplier_nxt;
   logic [P-1:0]    sum, sum_nxt;
   logic [P-1:0]    carry, carry_nxt;
   logic [CW-1:0]   count, count_nxt;
   logic [P-1:0]    product_nxt;
   logic            finished_nxt;
   logic [P-1:0]    pp;
   logic [P-1:0]    csa_sum;
   logic [P-1:0]    csa_carry;

   // The multiplicand is kept pre-shifted by 2i, so the partial product is just the
   // recoded digit applied to the current register value.
   always_comb begin
      pp = '0;
      unique case (mplier[2:0])
         3'b001, 3'b010: pp = mcand;
         3'b011:         pp = {mcand[P-2:0], 1'b0};
         3'b100:         pp = -{mcand[P-2:0], 1'b0};
         3'b101, 3'b110: pp = -mcand;
         default:        pp = '0;
      endcase
   end

   // 3:2 compression; the carry vector's bit 2N falls off the shifted result.
   always_comb begin
      csa_sum   = sum ^ carry ^ pp;
      csa_carry = ((sum & carry) | (sum & pp) | (carry & pp)) << 1;
   end

   always_comb begin
      state_nxt    = state;
      mcand_nxt    = mcand;
      mplier_nxt   = mplier;
      sum_nxt      = sum;
      carry_nxt    = carry;
      count_nxt    = count;
      product_nxt  = product;
      finished_nxt = 1'b0;

      if (flush) begin
         state_nxt = StIdle;
      end else begin
         unique case (state)
            StIdle: begin
               if (start) begin
                  mcand_nxt  = {{N{is_signed[1] & multiplicand[N-1]}}, multiplicand};
                  // Two extension bits on top, implicit bit -1 = 0 at the bottom.
                  mplier_nxt = {{2{is_signed[0] & multiplier[N-1]}}, multiplier, 1'b0};
                  sum_nxt    = '0;
                  carry_nxt  = '0;
                  count_nxt  = '0;
                  state_nxt  = StBusy;
               end
            end
            StBusy: begin
               sum_nxt    = csa_sum;
               carry_nxt  = csa_carry;
               mcand_nxt  = {mcand[P-3:0], 2'b00};
               mplier_nxt = {mplier[N+2], mplier[N+2], mplier[N+2:2]};
               if (count == LastDigit) begin
                  state_nxt = StAdd;
               end else begin
                  count_nxt = count + CW'(1);
               end
            end
            StAdd: begin
               product_nxt  = sum + carry;
               finished_nxt = 1'b1;
               state_nxt    = StIdle;
            end
            default: state_nxt = StIdle;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state    <= StIdle;
         mcand    <= '0;
         mplier   <= '0;
         sum      <= '0;
         carry    <= '0;
         count    <= '0;
         product  <= '0;
         finished <= 1'b0;
      end else begin
         state    <= state_nxt;
         mcand    <= mcand_nxt;
         mplier   <= mplier_nxt;
         sum      <= sum_nxt;
         carry    <= carry_nxt;
         count    <= count_nxt;
         product  <= product_nxt;
         finished <= finished_nxt;
      end
   end

   assign busy = (state != StIdle);

endmodule

// File: tb/tb_booth_csa_multiplier.sv
module tb_booth_csa_multiplier;

   logic        CLK;
   logic        nRST;
   logic [31:0] multiplicand;
   logic [31:0] multiplier;
   logic [1:0]  is_signed;
   logic        start;
   logic        flush;
   logic        busy;
   logic        finished;
   logic [63:0] product;

   int n_cmp;
   int n_err;

   booth_csa_multiplier #(.N(32)) dut (
      .CLK          (CLK),
      .nRST         (nRST),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .is_signed    (is_signed),
      .start        (start),
      .flush        (flush),
      .busy         (busy),
      .finished     (finished),
      .product      (product)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] sg);
      logic [63:0] ae;
      logic [63:0] be;
      ae = sg[1] ? {{32{a[31]}}, a} : {32'b0, a};
      be = sg[0] ? {{32{b[31]}}, b} : {32'b0, b};
      return ae * be;
   endfunction

   // Called at #1 after an edge; returns edges until finished is seen (bounded).
   task automatic wait_fin(input string tag, output int cyc);
      cyc = 0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge CLK);
         #1;
         cyc = i;
         if (finished) break;
      end
      if (!finished) check({tag, "_timeout"}, {63'b0, finished}, 64'd1);
   endtask

   task automatic drive_start(input logic [31:0] a, input logic [31:0] b, input logic [1:0] sg);
      multiplicand = a;
      multiplier   = b;
      is_signed    = sg;
      start        = 1'b1;
      @(posedge CLK);
      #1;
      start = 1'b0;
   endtask

   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] sg, input logic [63:0] exp);
      int cyc;
      drive_start(a, b, sg);
      check({tag, "_busy"}, {63'b0, busy}, 64'd1);
      wait_fin(tag, cyc);
      check({tag, "_lat"}, 64'(cyc), 64'd18);
      check(tag, product, exp);
      @(posedge CLK);
      #1;
      check({tag, "_pulse"}, {63'b0, finished}, 64'd0);
   endtask

   initial begin
      int cyc;
      logic any_fin;
      logic [31:0] ra;
      logic [31:0] rb;
      logic [1:0]  rs;
      n_cmp = 0;
      n_err = 0;
      nRST = 1'b0;
      multiplicand = '0;
      multiplier = '0;
      is_signed = 2'b00;
      start = 1'b0;
      flush = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      check("rst_product", product, 64'd0);
      check("rst_finished", {63'b0, finished}, 64'd0);
      check("rst_busy", {63'b0, busy}, 64'd0);
      nRST = 1'b1;
      @(posedge CLK);
      #1;

      run_op("u_3x5", 32'd3, 32'd5, 2'b00, 64'h0000_0000_0000_000F);
      run_op("u_ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 64'hFFFF_FFFE_0000_0001);
      run_op("s_ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 64'h0000_0000_0000_0001);
      run_op("s_80x80", 32'h8000_0000, 32'h8000_0000, 2'b11, 64'h4000_0000_0000_0000);
      run_op("su_ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 64'hFFFF_FFFF_0000_0001);
      run_op("us_ffx02", 32'hFFFF_FFFF, 32'h0000_0002, 2'b01, 64'h0000_0001_FFFF_FFFE);

      // Start re-pulsed with other operands mid-operation is ignored.
      drive_start(32'd100, 32'd200, 2'b00);
      repeat (4) @(posedge CLK);
      #1;
      multiplicand = 32'd7;
      multiplier = 32'd7;
      start = 1'b1;
      @(posedge CLK);
      #1;
      start = 1'b0;
      cyc = 0;
      wait_fin("repulse", cyc);
      check("repulse_lat", 64'(cyc + 5), 64'd18);
      check("repulse", product, 64'h0000_0000_0000_4E20);
      @(posedge CLK);
      #1;
      check("repulse_idle", {63'b0, busy}, 64'd0);

      // Start held through the finished cycle is accepted at that edge.
      multiplicand = 32'd6;
      multiplier = 32'd7;
      is_signed = 2'b00;
      start = 1'b1;
      @(posedge CLK);
      #1;
      wait_fin("b2b_first", cyc);
      check("b2b_first_lat", 64'(cyc), 64'd18);
      check("b2b_first", product, 64'h0000_0000_0000_002A);
      check("b2b_fin_busy", {63'b0, busy}, 64'd0);
      multiplicand = 32'd9;
      multiplier = 32'd11;
      @(posedge CLK);
      #1;
      start = 1'b0;
      multiplicand = 32'd1;
      multiplier = 32'd1;
      check("b2b_drop", {63'b0, finished}, 64'd0);
      check("b2b_busy", {63'b0, busy}, 64'd1);
      wait_fin("b2b_second", cyc);
      check("b2b_second_lat", 64'(cyc), 64'd18);
      check("b2b_second", product, 64'h0000_0000_0000_0063);
      @(posedge CLK);
      #1;

      // Flush at cycle 7: no completion, product unchanged.
      drive_start(32'd1000, 32'd1000, 2'b00);
      repeat (6) @(posedge CLK);
      #1;
      flush = 1'b1;
      @(posedge CLK);
      #1;
      flush = 1'b0;
      check("flush_busy", {63'b0, busy}, 64'd0);
      any_fin = 1'b0;
      for (int i = 0; i < 25; i++) begin
         @(posedge CLK);
         #1;
         any_fin = any_fin | finished;
      end
      check("flush_nofin", {63'b0, any_fin}, 64'd0);
      check("flush_hold", product, 64'h0000_0000_0000_0063);
      run_op("post_flush", 32'd1000, 32'd1000, 2'b00, 64'h0000_0000_000F_4240);

      // Reset mid-operation aborts at once.
      drive_start(32'd5, 32'd5, 2'b00);
      repeat (9) @(posedge CLK);
      #1;
      nRST = 1'b0;
      #1;
      check("mid_rst_product", product, 64'd0);
      check("mid_rst_finished", {63'b0, finished}, 64'd0);
      check("mid_rst_busy", {63'b0, busy}, 64'd0);
      @(posedge CLK);
      #1;
      nRST = 1'b1;
      any_fin = 1'b0;
      for (int i = 0; i < 25; i++) begin
         @(posedge CLK);
         #1;
         any_fin = any_fin | finished | busy;
      end
      check("rst_release_quiet", {63'b0, any_fin}, 64'd0);
      run_op("s_7xm2", 32'd7, 32'hFFFF_FFFE, 2'b11, 64'hFFFF_FFFF_FFFF_FFF2);

      // Random sweep over all signedness modes.
      for (int i = 0; i < 12; i++) begin
         ra = $urandom;
         rb = $urandom;
         rs = 2'(i % 4);
         run_op($sformatf("rand%0d_m%0d", i, rs), ra, rb, rs, ref_mul(ra, rb, rs));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
